vectrex_cart_loader: RTL and testbench

// - Sits between hps_io download stream and vectrex core: captures ROM image into on-chip cart RAM, serves CPU cart reads.
// - Derives power-of-two mirror mask from image size; generates core reset (hold during/after load, power-up).
// - Owns reset-timeout and address-mask logic for the core.

---
 rtl/vectrex_cart_loader.sv | 151 +++++++++++++++
 tb/tb_vectrex_cart_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vectrex_cart_loader.sv
// Cart loader for the vectrex core: captures the hps_io ROM download into cart RAM,
// serves CPU reads through a power-of-two mirror mask and owns the core reset.
// Optional feature: define CART_BANK_EN to add a second 2**ADDR_W byte bank selected by cpu_bank.
module vectrex_cart_loader #(
  parameter int ADDR_W      = 15,
  parameter int HOLD_CYCLES = 12_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] cpu_addr,
`ifdef CART_BANK_EN
  input  logic              cpu_bank,
  output logic [ADDR_W+1:0] cart_size,
`else
  output logic [ADDR_W:0]   cart_size,
`endif
  output logic [7:0]        cpu_data,
  output logic [ADDR_W-1:0] cart_mask,
  output logic              cart_loaded,
  output logic              overflow,
  output logic              cpu_reset
);

`ifdef CART_BANK_EN
  localparam int RAM_AW = ADDR_W + 1;
`else
  localparam int RAM_AW = ADDR_W;
`endif
  localparam int SIZE_W = RAM_AW + 1;
  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_LOAD
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   hold_cnt, hold_next;
  logic [ADDR_W-1:0]  mask_next;
  logic [SIZE_W-1:0]  size_next;
  logic               ovf_next, loaded_next;

  logic               dl_q, dl_rise, dl_fall;
  logic               wr_req, wr_in_range, wr_en;
  logic [RAM_AW-1:0]  wr_addr;
  logic [SIZE_W-1:0]  wr_end;
  logic [RAM_AW-1:0]  rd_addr;
  logic               rd_valid;
  logic [7:0]         ram_q;
  logic [7:0]         ram [2**RAM_AW];

  // Highest set bit of a and every bit below it; smear(0) = 0.
  function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = '0;
    for (int i = 0; i < ADDR_W; i++) s[i] = |(a >> i);
    return s;
  endfunction

  assign dl_rise     = ioctl_download & ~dl_q;
  assign dl_fall     = ~ioctl_download & dl_q;
  // Writes belong only to a window that opened with a rising edge seen by this block.
  assign wr_req      = ioctl_download & ioctl_wr & ((state == ST_LOAD) | dl_rise);
  assign wr_in_range = (ioctl_addr >> RAM_AW) == '0;
  assign wr_en       = wr_req & wr_in_range & ~reset;
  assign wr_addr     = ioctl_addr[RAM_AW-1:0];
  assign wr_end      = {1'b0, wr_addr} + 1'b1;

`ifdef CART_BANK_EN
  localparam logic [SIZE_W-1:0] BANK_SPLIT = SIZE_W'(2**ADDR_W);
  assign rd_addr = {cpu_bank & (cart_size > BANK_SPLIT), cpu_addr & cart_mask};
`else
  assign rd_addr = cpu_addr & cart_mask;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next  = state;
    mask_next   = dl_rise ? '0 : cart_mask;
    size_next   = dl_rise ? '0 : cart_size;
    ovf_next    = dl_rise ? 1'b0 : overflow;
    loaded_next = dl_rise ? 1'b0 : cart_loaded;

    if (dl_rise) begin
      state_next = ST_LOAD;
    end else begin
      case (state)
        ST_HOLD: if (hold_cnt == HOLD_LAST) state_next = ST_RUN;
        ST_LOAD: if (dl_fall) state_next = ST_HOLD;
        default: ;
      endcase
    end

    hold_next = (state == ST_HOLD && state_next == ST_HOLD) ? hold_cnt + 1'b1 : '0;

    if (wr_req) begin
      if (wr_in_range) begin
        if (wr_end > size_next) size_next = wr_end;
        mask_next = mask_next | smear(wr_addr[ADDR_W-1:0]);
`ifdef CART_BANK_EN
        if (wr_addr[ADDR_W]) mask_next = '1;
`endif
      end else begin
        ovf_next = 1'b1;
      end
    end

    if (state != ST_RUN && state_next == ST_RUN) loaded_next = (cart_size != '0);
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: dl_q follows the pin even through reset, so a window still open when reset
    // drops is not mistaken for a fresh rising edge.
    dl_q <= ioctl_download;
    if (reset) begin
      state       <= ST_HOLD;
      hold_cnt    <= '0;
      cart_mask   <= '0;
      cart_size   <= '0;
      overflow    <= 1'b0;
      cart_loaded <= 1'b0;
      cpu_reset   <= 1'b1;
      rd_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      cart_mask   <= mask_next;
      cart_size   <= size_next;
      overflow    <= ovf_next;
      cart_loaded <= loaded_next;
      cpu_reset   <= (state_next != ST_RUN);
      rd_valid    <= (state == ST_RUN) & cart_loaded;
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM;
  // the image survives a core reset.
  always_ff @(posedge clk_sys) begin
    if (wr_en) ram[wr_addr] <= ioctl_dout;
    ram_q <= ram[rd_addr];
  end

  assign cpu_data = rd_valid ? ram_q : 8'hFF;

endmodule

// File: tb/tb_vectrex_cart_loader.sv
// Self-checking bench for vectrex_cart_loader: directed sequence with random bytes and
// addresses, checked against a behavioural model of the cart image, mask and reset timing.
module tb_vectrex_cart_loader;
  localparam int ADDR_W = 15;
  localparam int HOLD   = 16;
`ifdef CART_BANK_EN
  localparam int DEPTH  = 1 << (ADDR_W + 1);
`else
  localparam int DEPTH  = 1 << ADDR_W;
`endif
  localparam int MASK_ALL = (1 << ADDR_W) - 1;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_data;
  logic [ADDR_W-1:0] cart_mask;
  logic              cart_loaded, overflow, cpu_reset;
`ifdef CART_BANK_EN
  logic              cpu_bank = 1'b0;
  logic [ADDR_W+1:0] cart_size;
`else
  logic [ADDR_W:0]   cart_size;
`endif

  vectrex_cart_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_addr(cpu_addr),
`ifdef CART_BANK_EN
    .cpu_bank(cpu_bank),
`endif
    .cpu_data(cpu_data), .cart_mask(cart_mask), .cart_size(cart_size),
    .cart_loaded(cart_loaded), .overflow(overflow), .cpu_reset(cpu_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Model of the cart image and the published image attributes.
  bit [7:0] m_mem [int];
  int       m_mask, m_size;
  bit       m_ovf, m_loaded, m_run;

  function automatic int smear_m(input int a);
    if (a == 0) return 0;
    return (1 << $clog2(a + 1)) - 1;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_mask = 0; m_size = 0; m_ovf = 0; m_loaded = 0; m_run = 0;
  endtask

  task automatic check_attrs(input string tag);
    check({tag, "_mask"}, 32'(cart_mask), 32'(m_mask));
    check({tag, "_size"}, 32'(cart_size), 32'(m_size));
    check({tag, "_ovf"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic do_reset();
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    reset = 1'b1;
    step();
    step();
    m_clear();
    check("rst_cpu_data", 32'(cpu_data), 32'hFF);
    check("rst_loaded", 32'(cart_loaded), 0);
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check_attrs("rst");
    reset = 1'b0;
  endtask

  // Counts cycles until cpu_reset drops; a missing release shows up as a wrong count.
  task automatic wait_release(input string tag, input int expect_cycles);
    int n;
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (cpu_reset === 1'b0) break;
    end
    check(tag, n, expect_cycles);
    m_run = 1;
    m_loaded = (m_size != 0);
    check({tag, "_loaded"}, 32'(cart_loaded), 32'(m_loaded));
  endtask

  task automatic load_start();
    ioctl_download = 1'b1;
    ioctl_wr = 1'b0;
    step();
    m_clear();
    check("load_cpu_reset", 32'(cpu_reset), 1);
    check("load_loaded", 32'(cart_loaded), 0);
    check_attrs("load_entry");
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    if (a < DEPTH) begin
      m_mem[a] = d;
      if (a + 1 > m_size) m_size = a + 1;
      m_mask = (m_mask | smear_m(a)) & MASK_ALL;
    end else begin
      m_ovf = 1;
    end
  endtask

  // Closes the window with a stray strobe on the falling-edge cycle, which must be ignored.
  task automatic load_end();
    ioctl_download = 1'b0;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(DEPTH - 1);
    ioctl_dout = 8'h77;
    step();
    ioctl_wr = 1'b0;
    m_run = 0;
    check("end_cpu_reset", 32'(cpu_reset), 1);
    wait_release("load_release", HOLD);
    check_attrs("after_load");
  endtask

  task automatic rd(input string tag, input int a);
    int k;
    logic [7:0] exp;
    cpu_addr = ADDR_W'(a);
    step();
    k = a & m_mask & MASK_ALL;
    if (m_run && m_loaded) begin
      if (!m_mem.exists(k)) return;
      exp = m_mem[k];
    end else begin
      exp = 8'hFF;
    end
    check(tag, 32'(cpu_data), 32'(exp));
  endtask

  initial begin
    int n;
    m_clear();

    // Power-up with no image.
    do_reset();
    wait_release("boot_release", HOLD);
    repeat (4) rd("boot_read", int'($urandom_range(0, MASK_ALL)));

    // Three-byte image mirrored over the whole window.
    load_start();
    wr_byte(0, 8'hA5);
    wr_byte(1, 8'h5A);
    wr_byte(2, 8'hC3);
    check("tiny_size", 32'(cart_size), 3);
    check("tiny_mask", 32'(cart_mask), 3);
    load_end();
    rd("tiny_wrap", 'h4001);
    check("tiny_wrap_const", 32'(cpu_data), 32'h5A);
    repeat (4) rd("tiny_rand", int'($urandom_range(0, MASK_ALL)));

    // 8 KB image followed by an out-of-range write.
    load_start();
    for (int i = 0; i < 8192; i++) wr_byte(i, 8'(i));
    check("8k_mask", 32'(cart_mask), 32'h1FFF);
    check("8k_size", 32'(cart_size), 32'h2000);
    wr_byte(DEPTH, 8'($urandom));
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_mask", 32'(cart_mask), 32'h1FFF);
    load_end();
    rd("8k_mirror", 'h2005);
    check("8k_mirror_const", 32'(cpu_data), 32'h05);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'd5;
    ioctl_dout = 8'hEE;
    step();
    ioctl_wr = 1'b0;
    rd("idle_wr_ignored", 5);
    repeat (6) rd("8k_rand", int'($urandom_range(0, MASK_ALL)));

    // Random image whose download starts while the hold counter is running.
    do_reset();
    repeat (3) step();
    load_start();
    n = int'($urandom_range(5, 40));
    for (int i = 0; i < n; i++) wr_byte(int'($urandom_range(0, 'h1FFF)), 8'($urandom));
    check_attrs("rand_load");
    load_end();
    repeat (8) rd("rand_read", int'($urandom_range(0, MASK_ALL)));

    // Reset in the middle of a download; the rest of that window is ignored.
    load_start();
    for (int i = 0; i < 100; i++) wr_byte(i, 8'($urandom));
    reset = 1'b1;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'd100;
    step();
    reset = 1'b0;
    m_clear();
    check("midrst_cpu_reset", 32'(cpu_reset), 1);
    check("midrst_loaded", 32'(cart_loaded), 0);
    check_attrs("midrst");
    ioctl_addr = 25'h10;
    ioctl_dout = 8'hEE;
    wait_release("midrst_release", HOLD);
    check("midrst_size_kept", 32'(cart_size), 0);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    step();
    repeat (2) rd("midrst_read", int'($urandom_range(0, MASK_ALL)));
    load_start();
    wr_byte('h1F, 8'($urandom));
    load_end();
    rd("midrst_ram_kept", 'h10);

`ifdef CART_BANK_EN
    load_start();
    wr_byte(0, 8'h00);
    wr_byte('h8000, 8'h80);
    wr_byte('hFFFF, 8'hFF);
    check_attrs("bank_load");
    load_end();
    cpu_bank = 1'b1;
    cpu_addr = '0;
    step();
    check("bank1_read", 32'(cpu_data), 32'h80);
    cpu_bank = 1'b0;
    step();
    check("bank0_read", 32'(cpu_data), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
